// File: rtl/CPU_package.sv
// Shared CPU definitions: register-bus word width and the write-bus arbiter state type.
package CPU_package;
    localparam int DATA_WIDTH = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of the eligible vector at or after
// the pointer, wrapping around, found by scanning a doubled and pointer-masked vector.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_valid
);
    logic [2*NUM_REQ-1:0] mask;
    logic [2*NUM_REQ-1:0] dbl;

    always_comb begin
        mask          = {(2*NUM_REQ){1'b1}} << pointer;
        dbl           = {eligible, eligible} & mask;
        any_valid     = |eligible;
        winner_idx    = '0;
        winner_onehot = '0;
        // Descending scan so the lowest masked bit, i.e. the first one after the pointer, wins.
        for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
            if (dbl[k]) begin
                winner_idx = (k >= NUM_REQ) ? PTR_W'(k - NUM_REQ) : PTR_W'(k);
            end
        end
        if (any_valid) begin
            winner_onehot[winner_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the shared register write bus, with bounded bus lock.
// Registered grant, one-hot register load enable and bus data; out-of-range targets are dropped.
module reg_bus_arbiter
    import CPU_package::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  NUM_REGS = 6,
    parameter int  MAX_LOCK = 4,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                          iclk,
    input  logic                          irst_n,
    input  logic [NUM_REQ-1:0]            ireq,
    input  logic [NUM_REQ-1:0]            ilock,
    input  logic [NUM_REQ*SEL_W-1:0]      idst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] idata,
    output logic [NUM_REQ-1:0]            ogrant,
    output logic [NUM_REGS-1:0]           oen,
    output logic [DATA_WIDTH-1:0]         odata,
    output logic                          oerr,
    output logic                          obusy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t             state, state_nx;
    logic [PTR_W-1:0]       ptr, ptr_nx;
    logic [PTR_W-1:0]       owner, owner_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [PTR_W-1:0]       win_idx;
    logic                   any_valid;
    logic                   do_grant;
    logic [SEL_W-1:0]       sel_dst;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   dst_ok;
    logic [NUM_REQ-1:0]     grant_nx;
    logic [NUM_REGS-1:0]    en_nx;
    logic [DATA_WIDTH-1:0]  data_nx;
    logic                   err_nx;

    // A source whose grant is currently shown sits out one cycle, except the lock owner.
    assign eligible = (state == ARB_LOCKED) ? (ireq & (NUM_REQ'(1) << owner))
                                            : (ireq & ~ogrant);

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_picker (
        .eligible     (eligible),
        .pointer      (ptr),
        .winner_onehot(win_onehot),
        .winner_idx   (win_idx),
        .any_valid    (any_valid)
    );

    assign sel_dst  = idst[win_idx*SEL_W +: SEL_W];
    assign sel_data = idata[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign dst_ok   = (32'(sel_dst) < NUM_REGS);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        do_grant = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    do_grant = 1'b1;
                    ptr_nx   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                    if (ilock[win_idx] && (MAX_LOCK > 1)) begin
                        state_nx = ARB_LOCKED;
                        owner_nx = win_idx;
                        cnt_nx   = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                if (any_valid) begin
                    do_grant = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                    if (!ilock[owner] || (cnt_nx >= CNT_W'(MAX_LOCK))) begin
                        state_nx = ARB_IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    state_nx = ARB_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                cnt_nx   = '0;
            end
        endcase

        grant_nx = do_grant ? win_onehot : '0;
        en_nx    = (do_grant && dst_ok) ? (NUM_REGS'(1) << sel_dst) : '0;
        err_nx   = do_grant && !dst_ok;
        data_nx  = do_grant ? sel_data : '0;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state  <= ARB_IDLE;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            ogrant <= '0;
            oen    <= '0;
            odata  <= '0;
            oerr   <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            owner  <= owner_nx;
            cnt    <= cnt_nx;
            ogrant <= grant_nx;
            oen    <= en_nx;
            odata  <= data_nx;
            oerr   <= err_nx;
        end
    end

    assign obusy = (state == ARB_LOCKED);
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic, all checked against
// a behavioural round-robin/lock model and a register-file scoreboard.
module tb_reg_bus_arbiter;
    import CPU_package::*;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 6;
    localparam int MAX_LOCK = 4;
    localparam int SEL_W    = 3;
    localparam int DW       = DATA_WIDTH;
    localparam int BOUND    = (NUM_REQ-1)*MAX_LOCK + NUM_REQ;

    logic                     iclk = 1'b0;
    logic                     irst_n;
    logic [NUM_REQ-1:0]       ireq, ilock;
    logic [NUM_REQ*SEL_W-1:0] idst;
    logic [NUM_REQ*DW-1:0]    idata;
    logic [NUM_REQ-1:0]       ogrant;
    logic [NUM_REGS-1:0]      oen;
    logic [DW-1:0]            odata;
    logic                     oerr, obusy;

    int n_checks = 0;
    int n_errors = 0;

    bit               m_locked;
    int               m_owner, m_cnt, m_ptr, m_last;
    logic [NUM_REQ-1:0]  e_grant;
    logic [NUM_REGS-1:0] e_en;
    logic [DW-1:0]       e_data;
    logic                e_err, e_busy;
    logic [DW-1:0]       m_regs [NUM_REGS];
    logic [DW-1:0]       d_regs [NUM_REGS];
    int                  wt [NUM_REQ];

    reg_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .MAX_LOCK(MAX_LOCK)
    ) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .ireq  (ireq),
        .ilock (ilock),
        .idst  (idst),
        .idata (idata),
        .ogrant(ogrant),
        .oen   (oen),
        .odata (odata),
        .oerr  (oerr),
        .obusy (obusy)
    );

    always #5 iclk = ~iclk;

    // Destination registers as the bus would load them.
    always @(posedge iclk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (oen[r]) d_regs[r] <= odata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_src(input int s, input bit rq, input bit lk, input int dst, input logic [DW-1:0] d);
        ireq[s]                  = rq;
        ilock[s]                 = lk;
        idst[s*SEL_W +: SEL_W]   = SEL_W'(dst);
        idata[s*DW +: DW]        = d;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = 0;
        m_last   = -1;
        e_grant  = '0;
        e_en     = '0;
        e_data   = '0;
        e_err    = 1'b0;
        e_busy   = 1'b0;
    endtask

    // Reference: the write shown last cycle lands now; then pick the next winner by rule.
    task automatic model_step();
        int win;
        int dst;
        win = -1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (e_en[r]) m_regs[r] = e_data;
        end
        if (m_locked) begin
            if (ireq[m_owner]) win = m_owner;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int s;
                s = (m_ptr + i) % NUM_REQ;
                if (win < 0 && ireq[s] && s != m_last) win = s;
            end
        end
        if (m_locked) begin
            if (win >= 0) begin
                m_cnt++;
                if (!ilock[win] || m_cnt >= MAX_LOCK) m_locked = 1'b0;
            end else begin
                m_locked = 1'b0;
            end
        end else if (win >= 0) begin
            m_ptr = (win + 1) % NUM_REQ;
            if (ilock[win] && MAX_LOCK > 1) begin
                m_locked = 1'b1;
                m_owner  = win;
                m_cnt    = 1;
            end
        end
        e_grant = '0;
        e_en    = '0;
        e_data  = '0;
        e_err   = 1'b0;
        if (win >= 0) begin
            e_grant[win] = 1'b1;
            dst          = int'(idst[win*SEL_W +: SEL_W]);
            e_data       = idata[win*DW +: DW];
            if (dst < NUM_REGS) e_en[dst] = 1'b1;
            else                e_err     = 1'b1;
        end
        e_busy = m_locked;
        m_last = win;
    endtask

    task automatic cycle();
        @(posedge iclk);
        if (!irst_n) model_reset();
        else         model_step();
        #1;
        check_val("grant", 32'(ogrant), 32'(e_grant));
        check_val("en",    32'(oen),    32'(e_en));
        check_val("data",  32'(odata),  32'(e_data));
        check_val("err",   32'(oerr),   32'(e_err));
        check_val("busy",  32'(obusy),  32'(e_busy));
    endtask

    task automatic rand_src(input int s);
        set_src(s, 1'b1, ($urandom % 4) == 0, int'($urandom % 8), DW'($urandom));
    endtask

    logic [NUM_REQ-1:0] exp1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NUM_REQ-1:0] exp3 [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    logic               busy3 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        irst_n = 1'b0;
        ireq   = '0;
        ilock  = '0;
        idst   = '0;
        idata  = '0;
        model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = '0;
            d_regs[r] = '0;
        end
        for (int s = 0; s < NUM_REQ; s++) wt[s] = 0;

        // Reset with every source requesting, then plain round robin.
        for (int s = 0; s < NUM_REQ; s++) set_src(s, 1'b1, 1'b0, s + 1, DW'(16'h1000 * (s + 1) + s));
        repeat (2) cycle();
        check_val("rst_grant", 32'(ogrant), 32'd0);
        check_val("rst_data",  32'(odata),  32'd0);
        #3 irst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("rr_order", 32'(ogrant), 32'(exp1[i]));
        end

        // Single requester, drops request on seeing its grant.
        ireq = '0;
        repeat (2) cycle();
        set_src(2, 1'b1, 1'b0, 3, 16'hBEEF);
        cycle();
        check_val("single_grant", 32'(ogrant), 32'h4);
        check_val("single_en",    32'(oen),    32'h08);
        check_val("single_data",  32'(odata),  32'hBEEF);
        ireq[2] = 1'b0;
        cycle();
        check_val("single_nodup", 32'(ogrant), 32'h0);

        // Lock by src1 bounded at MAX_LOCK, then round robin resumes past it.
        set_src(1, 1'b1, 1'b1, 2, 16'h1111);
        cycle();
        set_src(0, 1'b1, 1'b0, 4, 16'h0A0A);
        set_src(3, 1'b1, 1'b0, 5, 16'h3B3B);
        check_val("lock_seq", 32'(ogrant), 32'(exp3[0]));
        check_val("lock_busy", 32'(obusy), 32'(busy3[0]));
        for (int i = 1; i < 6; i++) begin
            cycle();
            check_val("lock_seq",  32'(ogrant), 32'(exp3[i]));
            check_val("lock_busy", 32'(obusy),  32'(busy3[i]));
        end
        ireq  = '0;
        ilock = '0;
        repeat (2) cycle();

        // Out-of-range destination: granted but dropped.
        set_src(0, 1'b1, 1'b0, 7, 16'h7777);
        cycle();
        check_val("bad_grant", 32'(ogrant), 32'h1);
        check_val("bad_en",    32'(oen),    32'h0);
        check_val("bad_err",   32'(oerr),   32'h1);
        ireq = '0;
        cycle();
        check_val("bad_err_pulse", 32'(oerr), 32'h0);

        // Asynchronous reset in the middle of a locked grant.
        set_src(2, 1'b1, 1'b1, 1, 16'h2222);
        repeat (2) cycle();
        check_val("mid_busy",  32'(obusy),  32'h1);
        check_val("mid_grant", 32'(ogrant), 32'h4);
        #2 irst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_grant", 32'(ogrant), 32'h0);
        check_val("async_en",    32'(oen),    32'h0);
        check_val("async_data",  32'(odata),  32'h0);
        check_val("async_busy",  32'(obusy),  32'h0);
        #1 irst_n = 1'b1;
        for (int s = 0; s < NUM_REQ; s++) set_src(s, 1'b1, 1'b0, s, DW'(16'h5000 + s));
        cycle();
        check_val("post_rst_first", 32'(ogrant), 32'h1);
        ireq  = '0;
        ilock = '0;
        cycle();

        // Random traffic; a source holding lock keeps requesting after its grant.
        for (int c = 0; c < 10000; c++) begin
            cycle();
            check_val("grant_1hot", 32'($onehot0(ogrant)), 32'd1);
            check_val("en_1hot",    32'($onehot0(oen)),    32'd1);
            for (int s = 0; s < NUM_REQ; s++) begin
                if (e_grant[s]) begin
                    check_val("wait_bound", 32'(wt[s] <= BOUND), 32'd1);
                    wt[s] = 0;
                    if (ilock[s] || ($urandom % 2) == 0) rand_src(s);
                    else begin
                        ireq[s]  = 1'b0;
                        ilock[s] = 1'b0;
                    end
                end else if (ireq[s]) begin
                    wt[s]++;
                end else if (($urandom % 4) == 0) begin
                    rand_src(s);
                end
            end
        end

        ireq  = '0;
        ilock = '0;
        repeat (2) cycle();
        for (int r = 0; r < NUM_REGS; r++) check_val("reg_file", 32'(d_regs[r]), 32'(m_regs[r]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
